// File: rtl/stonyman_adc_capture_pkg.sv
// Shared types and sizes for the Stonyman imager ADC capture path.
package stonyman_pkg;
   localparam int ADC_FRAME_BITS = 16;
   localparam int ADC_DATA_BITS  = 12;
   localparam int PIXEL_ADDR_W   = 14;
   localparam int STONYMAN_ROWS  = 112;
   localparam int STONYMAN_COLS  = 112;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_SHIFT,
      ST_QUIET,
      ST_DONE
   } cap_state_e;

   // Frame-buffer address step with wrap at the end of the frame.
   function automatic logic [PIXEL_ADDR_W-1:0] pixel_addr_next(
      input logic [PIXEL_ADDR_W-1:0] addr,
      input int                      num_pixels
   );
      if (int'(addr) >= num_pixels - 1) return '0;
      return addr + 1'b1;
   endfunction
endpackage

// File: rtl/stonyman_adc_capture_if.sv
// Capture-side bundle: conversion request, serial ADC pins and pixel write port.
interface stonyman_adc_capture_if;
   import stonyman_pkg::*;

   logic                     adc_capture_start;
   logic                     frame_start;
   logic                     adc_sdata;
   logic                     adc_cs_n;
   logic                     adc_sclk;
   logic                     adc_capture_done;
   logic [ADC_DATA_BITS-1:0] sample_data;
   logic                     pixel_we;
   logic [PIXEL_ADDR_W-1:0]  pixel_waddr;
   logic                     capture_busy;

   modport master (
      output adc_capture_start, frame_start, adc_sdata,
      input  adc_cs_n, adc_sclk, adc_capture_done, sample_data,
             pixel_we, pixel_waddr, capture_busy
   );

   modport slave (
      input  adc_capture_start, frame_start, adc_sdata,
      output adc_cs_n, adc_sclk, adc_capture_done, sample_data,
             pixel_we, pixel_waddr, capture_busy
   );
endinterface

// File: rtl/stonyman_adc_capture_tick.sv
// SCLK half-period enable: pulses every CLK_DIV cycles while not cleared.
module stonyman_adc_tick #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);
   logic [7:0] cnt;

   assign tick = !clr && (cnt == 8'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)            cnt <= '0;
      else if (clr || tick)  cnt <= '0;
      else                   cnt <= cnt + 8'd1;
   end
endmodule

// File: rtl/stonyman_adc_capture.sv
// Serial ADC capture: one 16-bit SPI-style read per request, low 12 bits
// written to the frame buffer at a self-incrementing pixel address.
module stonyman_adc_capture
   import stonyman_pkg::*;
#(
   parameter int CLK_DIV      = 2,
   parameter int QUIET_CYCLES = 2,
   parameter int NUM_PIXELS   = STONYMAN_ROWS * STONYMAN_COLS
) (
   input  logic                 clk,
   input  logic                 reset,
   stonyman_adc_capture_if.slave bus
);
   cap_state_e                state, state_nx;
   logic                      tick;
   logic [4:0]                half_cnt;
   logic [7:0]                quiet_cnt;
   logic [ADC_FRAME_BITS-1:0] shreg;
   logic [PIXEL_ADDR_W-1:0]   addr;

   stonyman_adc_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (state != ST_SHIFT),
      .tick  (tick)
   );

   assign bus.pixel_waddr = addr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:     if (bus.adc_capture_start) state_nx = ST_CS_SETUP;
         ST_CS_SETUP: state_nx = ST_SHIFT;
         ST_SHIFT:    if (tick && half_cnt == 5'd31)
                         state_nx = (QUIET_CYCLES == 0) ? ST_DONE : ST_QUIET;
         ST_QUIET:    if (quiet_cnt == 8'd0) state_nx = ST_DONE;
         ST_DONE:     state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase
   end

   // Pin and status outputs are registered from the next state so they line
   // up with the state they describe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.adc_cs_n         <= 1'b1;
         bus.adc_sclk         <= 1'b1;
         bus.adc_capture_done <= 1'b0;
         bus.pixel_we         <= 1'b0;
         bus.capture_busy     <= 1'b0;
         bus.sample_data      <= '0;
         half_cnt             <= '0;
         quiet_cnt            <= '0;
         shreg                <= '0;
         addr                 <= '0;
      end else begin
         bus.adc_cs_n         <= !(state_nx == ST_CS_SETUP || state_nx == ST_SHIFT);
         bus.adc_capture_done <= (state_nx == ST_DONE);
         bus.pixel_we         <= (state_nx == ST_DONE);
         bus.capture_busy     <= (state_nx != ST_IDLE);

         // Low phase first; the final high phase is held through CS release.
         if (state_nx != ST_SHIFT)    bus.adc_sclk <= 1'b1;
         else if (state != ST_SHIFT)  bus.adc_sclk <= 1'b0;
         else if (tick)               bus.adc_sclk <= ~bus.adc_sclk;

         if (state != ST_SHIFT) half_cnt <= '0;
         else if (tick)         half_cnt <= half_cnt + 5'd1;

         // Even half-count ticks end a low phase: that edge raises SCLK.
         if (tick && !half_cnt[0])
            shreg <= {shreg[ADC_FRAME_BITS-2:0], bus.adc_sdata};

         if (state != ST_QUIET) quiet_cnt <= 8'(QUIET_CYCLES - 1);
         else                   quiet_cnt <= quiet_cnt - 8'd1;

         if (state_nx == ST_DONE) bus.sample_data <= shreg[ADC_DATA_BITS-1:0];

         if (bus.frame_start)     addr <= '0;
         else if (state == ST_DONE) addr <= pixel_addr_next(addr, NUM_PIXELS);
      end
   end
endmodule
